// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
// Module      : game_controller
// Description : Top-level game sequencer for a flappy-bird style game.
//               Detects key presses, runs the IDLE / PLAYING / GAME_OVER
//               state machine, keeps a two-digit BCD score and high score,
//               and enforces a press lockout after the bird dies.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i            : system clock, all state updates on the rising edge
//   reset_i          : asynchronous active-high reset
//   btn_i            : flap/start key level (synchronous to clk_i)
//   bird_y_i[3:0]    : current bird row from the physics block, 0 = top
//   collision_i      : high while the bird overlaps a pipe
//   pipe_passed_i    : single-cycle pulse when a pipe is cleared
//   playing_o        : physics enable, high only in PLAYING
//   flap_o           : registered single-cycle flap pulse
//   physics_reset_o  : physics block reset level, high only in IDLE
//   game_over_o      : high only in GAME_OVER
//   score_o[7:0]     : current score, BCD tens in [7:4], units in [3:0]
//   high_score_o[7:0]: best score since reset, BCD
//   state_o[1:0]     : IDLE=00, PLAYING=01, GAME_OVER=10
// ============================================================================
module game_controller #(
  parameter int unsigned LOCKOUT  = 50_000_000,
  parameter logic [3:0]  GROUND_Y = 4'd15
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       btn_i,
  input  logic [3:0] bird_y_i,
  input  logic       collision_i,
  input  logic       pipe_passed_i,
  output logic       playing_o,
  output logic       flap_o,
  output logic       physics_reset_o,
  output logic       game_over_o,
  output logic [7:0] score_o,
  output logic [7:0] high_score_o,
  output logic [1:0] state_o
);

  localparam logic [1:0] S_IDLE      = 2'b00;
  localparam logic [1:0] S_PLAYING   = 2'b01;
  localparam logic [1:0] S_GAME_OVER = 2'b10;

  localparam int unsigned       CNT_W    = $clog2(LOCKOUT);
  localparam logic [CNT_W-1:0]  LOCK_MAX = CNT_W'(LOCKOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             btn_q;
  logic             flap_q, flap_d;
  logic [7:0]       score_q, score_d;
  logic [7:0]       high_q, high_d;
  logic [CNT_W-1:0] lock_q, lock_d;

  logic press;
  logic death;
  logic lock_done;

  // btn_q resets high so a key held through reset release is not a press.
  assign press     = btn_i & ~btn_q;
  assign death     = collision_i | (bird_y_i == GROUND_Y);
  assign lock_done = (lock_q == LOCK_MAX);

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (press) state_d = S_PLAYING;
      end
      S_PLAYING: begin
        if (death) state_d = S_GAME_OVER;
      end
      S_GAME_OVER: begin
        if (press && lock_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode: state register only, no input-to-output paths
  // --------------------------------------------------------------------------
  always_comb begin
    playing_o       = (state_q == S_PLAYING);
    physics_reset_o = (state_q == S_IDLE);
    game_over_o     = (state_q == S_GAME_OVER);
    state_o         = state_q;
  end

  assign flap_o       = flap_q;
  assign score_o      = score_q;
  assign high_score_o = high_q;

  // --------------------------------------------------------------------------
  // Datapath next-state: flap, score, high score, lockout counter
  // --------------------------------------------------------------------------
  always_comb begin
    flap_d  = 1'b0;
    score_d = score_q;
    high_d  = high_q;
    lock_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (press) score_d = 8'h00;
      end
      S_PLAYING: begin
        if (death) begin
          // Death takes priority over scoring and flapping this cycle.
          if (score_q > high_q) high_d = score_q;
        end else begin
          flap_d = press;
          if (pipe_passed_i) score_d = bcd_inc(score_q);
        end
      end
      S_GAME_OVER: begin
        // Counter is zero on entry (held at zero outside GAME_OVER).
        lock_d = lock_done ? lock_q : lock_q + 1'b1;
      end
      default: begin
        flap_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      btn_q   <= 1'b1;
      flap_q  <= 1'b0;
      score_q <= 8'h00;
      high_q  <= 8'h00;
      lock_q  <= '0;
    end else begin
      btn_q   <= btn_i;
      flap_q  <= flap_d;
      score_q <= score_d;
      high_q  <= high_d;
      lock_q  <= lock_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_game_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_controller
// Description : Self-checking bench for game_controller (LOCKOUT=8,
//               GROUND_Y=15). Expected values are queued when stimulus is
//               applied and drained against the DUT outputs afterwards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_controller;

  localparam int unsigned LOCKOUT  = 8;
  localparam logic [3:0]  GROUND_Y = 4'd15;

  localparam int SEL_STATE = 0;
  localparam int SEL_SCORE = 1;
  localparam int SEL_HIGH  = 2;
  localparam int SEL_FLAP  = 3;
  localparam int SEL_PLAY  = 4;
  localparam int SEL_GO    = 5;
  localparam int SEL_PRST  = 6;
  localparam int SEL_FCNT  = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn;
  logic [3:0] bird_y;
  logic       collision;
  logic       pipe_passed;
  logic       playing;
  logic       flap;
  logic       physics_reset;
  logic       game_over;
  logic [7:0] score;
  logic [7:0] high_score;
  logic [1:0] state;

  game_controller #(
    .LOCKOUT  (LOCKOUT),
    .GROUND_Y (GROUND_Y)
  ) u_dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .btn_i           (btn),
    .bird_y_i        (bird_y),
    .collision_i     (collision),
    .pipe_passed_i   (pipe_passed),
    .playing_o       (playing),
    .flap_o          (flap),
    .physics_reset_o (physics_reset),
    .game_over_o     (game_over),
    .score_o         (score),
    .high_score_o    (high_score),
    .state_o         (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   flap_cnt = 0;
  int   exp_score = 0;   // bench model of the score as a plain integer

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [7:0] observe(input int sel);
    logic [7:0] r;
    case (sel)
      SEL_STATE: r = {6'd0, state};
      SEL_SCORE: r = score;
      SEL_HIGH:  r = high_score;
      SEL_FLAP:  r = {7'd0, flap};
      SEL_PLAY:  r = {7'd0, playing};
      SEL_GO:    r = {7'd0, game_over};
      SEL_PRST:  r = {7'd0, physics_reset};
      default:   r = 8'(flap_cnt);
    endcase
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One pipe_passed pulse every other cycle; model saturates at 99.
  task automatic pulse_pipe(input int n);
    repeat (n) begin
      pipe_passed = 1'b1;
      @(negedge clk);
      pipe_passed = 1'b0;
      @(negedge clk);
      if (exp_score < 99) exp_score++;
    end
  endtask

  task automatic expect_reset_values(input string pfx);
    expect_val({pfx, "_state"}, SEL_STATE, 8'h00);
    expect_val({pfx, "_score"}, SEL_SCORE, 8'h00);
    expect_val({pfx, "_high"},  SEL_HIGH,  8'h00);
    expect_val({pfx, "_flap"},  SEL_FLAP,  8'h00);
    expect_val({pfx, "_play"},  SEL_PLAY,  8'h00);
    expect_val({pfx, "_go"},    SEL_GO,    8'h00);
    expect_val({pfx, "_prst"},  SEL_PRST,  8'h01);
  endtask

  initial begin
    reset       = 1'b1;
    btn         = 1'b0;
    bird_y      = 4'd5;
    collision   = 1'b0;
    pipe_passed = 1'b0;

    // Reset state
    #3;
    expect_reset_values("por");
    sb_drain();
    @(negedge clk);
    reset = 1'b0;
    step(2);

    // Start from IDLE: physics_reset falls together with the state change
    expect_val("idle_state", SEL_STATE, 8'h00);
    expect_val("idle_prst",  SEL_PRST,  8'h01);
    sb_drain();
    btn = 1'b1;
    step(1);
    exp_score = 0;
    expect_val("start_state", SEL_STATE, 8'h01);
    expect_val("start_play",  SEL_PLAY,  8'h01);
    expect_val("start_prst",  SEL_PRST,  8'h00);
    expect_val("start_score", SEL_SCORE, 8'h00);
    expect_val("start_flap",  SEL_FLAP,  8'h00);
    sb_drain();
    btn = 1'b0;
    step(1);
    expect_val("start_flap2", SEL_FLAP, 8'h00);
    sb_drain();

    // Held button gives one single-cycle flap; a second press gives another
    for (int p = 0; p < 2; p++) begin
      flap_cnt = 0;
      btn = 1'b1;
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        if (flap) flap_cnt++;
        if (i == 4) btn = 1'b0;
      end
      expect_val((p == 0) ? "flap_hold" : "flap_second", SEL_FCNT, 8'd1);
      sb_drain();
    end

    // Score 7, then ground contact with simultaneous pipe_passed
    pulse_pipe(7);
    expect_val("score7", SEL_SCORE, to_bcd(exp_score));
    sb_drain();
    bird_y      = GROUND_Y;
    pipe_passed = 1'b1;
    step(1);
    bird_y      = 4'd5;
    pipe_passed = 1'b0;
    expect_val("die_state", SEL_STATE, 8'h02);
    expect_val("die_score", SEL_SCORE, 8'h07);
    expect_val("die_high",  SEL_HIGH,  8'h07);
    expect_val("die_play",  SEL_PLAY,  8'h00);
    expect_val("die_go",    SEL_GO,    8'h01);
    sb_drain();

    // Lockout: presses while counter < LOCKOUT-1 are ignored
    step(2);
    btn = 1'b1;                // sampled with counter = 2
    step(1);
    btn = 1'b0;
    expect_val("lock_early", SEL_STATE, 8'h02);
    sb_drain();
    step(3);
    btn = 1'b1;                // sampled with counter = 6
    step(1);
    btn = 1'b0;
    expect_val("lock_edge", SEL_STATE, 8'h02);
    sb_drain();
    step(1);
    btn = 1'b1;                // sampled with counter = 7
    step(1);
    btn = 1'b0;
    expect_val("lock_exit_state", SEL_STATE, 8'h00);
    expect_val("lock_exit_prst",  SEL_PRST,  8'h01);
    expect_val("lock_exit_score", SEL_SCORE, 8'h07);
    sb_drain();
    step(1);
    btn = 1'b1;
    step(1);
    btn = 1'b0;
    exp_score = 0;
    expect_val("restart_state", SEL_STATE, 8'h01);
    expect_val("restart_score", SEL_SCORE, 8'h00);
    expect_val("restart_high",  SEL_HIGH,  8'h07);
    sb_drain();

    // Asynchronous reset mid-GAME_OVER with the key held
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    expect_val("go2_go", SEL_GO, 8'h01);
    sb_drain();
    btn = 1'b1;
    step(2);
    #2;
    reset = 1'b1;
    #1;
    expect_reset_values("async");
    sb_drain();
    @(negedge clk);
    reset = 1'b0;
    step(3);
    expect_val("held_no_press", SEL_STATE, 8'h00);
    sb_drain();
    btn = 1'b0;
    step(1);
    btn = 1'b1;
    step(1);
    btn = 1'b0;
    exp_score = 0;
    expect_val("repress_state", SEL_STATE, 8'h01);
    sb_drain();

    // BCD counting, carries and saturation
    pulse_pipe(12);
    expect_val("score12", SEL_SCORE, to_bcd(exp_score));
    expect_val("score12_state", SEL_STATE, 8'h01);
    sb_drain();
    pulse_pipe(87);
    expect_val("score99", SEL_SCORE, to_bcd(exp_score));
    sb_drain();
    pulse_pipe(1);
    expect_val("score99_sat", SEL_SCORE, to_bcd(exp_score));
    sb_drain();

    // Collision and press together: death wins, no flap
    collision = 1'b1;
    btn       = 1'b1;
    step(1);
    collision = 1'b0;
    expect_val("dp_state", SEL_STATE, 8'h02);
    expect_val("dp_flap",  SEL_FLAP,  8'h00);
    expect_val("dp_high",  SEL_HIGH,  8'h99);
    sb_drain();
    step(1);
    btn = 1'b0;
    expect_val("dp_flap2", SEL_FLAP, 8'h00);
    sb_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter: LOCKOUT, default 50_000_000, GAME_OVER cycles during which presses are ignored (>=2).
REQ-002 Parameter: GROUND_Y, default 15, bird_y value that counts as hitting the ground.
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 btn  input  1  flap/start key level, already synchronous to clk, active-high.
REQ-006 bird_y  input  4  current bird row from the physics block; 0 = top.
REQ-007 collision  input  1  level, high while bird overlaps a pipe.
REQ-008 pipe_passed  input  1  single-cycle pulse when the bird clears a pipe.
REQ-009 playing  output  1  enables the physics block; high only in PLAYING.
REQ-010 flap  output  1  registered single-cycle flap pulse to the physics block.
REQ-011 physics_reset  output  1  synchronous reset level to the physics block; high only in IDLE.
REQ-012 game_over  output  1  high only in GAME_OVER.
REQ-013 score  output  8  current score, two BCD digits ([7:4] tens, [3:0] units).
REQ-014 high_score  output  8  best score since reset, two BCD digits.
REQ-015 state  output  2  IDLE=00, PLAYING=01, GAME_OVER=10; 11 unused.

Function
REQ-016 The block SHALL register btn into btn_q each cycle; press = btn & ~btn_q.
REQ-017 IDLE: press SHALL move to PLAYING at the next edge, clear score to 00, and SHALL NOT raise flap.
REQ-018 PLAYING: each press SHALL set flap high for exactly the one cycle following the sampling edge; holding btn yields one pulse only.
REQ-019 PLAYING: pipe_passed SHALL increment score in BCD (09->10, 19->20), saturating at 99.
REQ-020 PLAYING: collision==1 or bird_y==GROUND_Y SHALL move to GAME_OVER at the next edge.
REQ-021 Death and pipe_passed in the same cycle: death wins, score unchanged.
REQ-022 Death and press in the same cycle: death wins, flap stays 0.
REQ-023 On PLAYING->GAME_OVER, high_score SHALL load score if score > high_score (plain 8-bit compare), else hold.
REQ-024 GAME_OVER: lockout counter SHALL clear on entry and increment each cycle, saturating at LOCKOUT-1; presses before saturation are ignored.
REQ-025 GAME_OVER: press with counter at LOCKOUT-1 SHALL move to IDLE at the next edge; score holds until the next IDLE->PLAYING.
REQ-026 playing, physics_reset, game_over and state SHALL be decoded from the state register only (no input-to-output paths).
REQ-027 flap SHALL be 0 in every state other than PLAYING.
REQ-028 Unused state 11 SHALL transition to IDLE at the next edge.

Reset
REQ-029 On reset assertion, without waiting for clk: state=IDLE, score=00, high_score=00, flap=0, playing=0, game_over=0, physics_reset=1, lockout counter=0.
REQ-030 btn_q SHALL reset to 1, so a key held through reset release is not a press.
REQ-031 Reset asserted mid-PLAYING or mid-GAME_OVER SHALL behave identically to power-on reset; high_score is also cleared.

Verification (LOCKOUT=8, GROUND_Y=15)
REQ-032 Reset, btn low, press -> state 00->01, score=00, flap never high, physics_reset falls with state change.
REQ-033 In PLAYING, btn held 5 cycles -> exactly one flap pulse one cycle wide; second press after release -> second pulse.
REQ-034 In PLAYING, 12 pipe_passed pulses -> score=0x12; starting from 0x99, one more pulse -> score stays 0x99.
REQ-035 In PLAYING with score=0x07, bird_y=15 with simultaneous pipe_passed -> GAME_OVER, score=0x07, high_score=0x07, playing=0.
REQ-036 In GAME_OVER, press at cycle 3 -> ignored; press after 8 cycles -> IDLE, physics_reset=1; next press -> PLAYING, score=00, high_score=0x07.
REQ-037 Reset asserted asynchronously mid-GAME_OVER with btn held -> outputs at reset values before the next edge; no press detected after release until btn falls and rises.
